instr_fetch_unit: RTL and testbench

- Supplies the instruction stream that the microprocessor core consumes.
- Generates instruction-memory read addresses from a fetch PC and captures read data from the 1-cycle-latency synchronous instruction memory.
- Buffers fetched words with their PCs in a small FIFO and hands them to the core over a valid/ready handshake.
- Handles PC redirects (branch/jump) from the core: flushes the FIFO and discards stale in-flight reads.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_fifo.sv | 45 ++++
 rtl/instr_fetch_unit.sv | 88 ++++++++
 tb/tb_instr_fetch_unit.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and types for the instruction fetch unit
package fetch_pkg;
    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 32;
    localparam int INSTR_BYTES = 4;
    localparam logic [DATA_WIDTH-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic {IDLE, RUN} fetch_state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO of fetch entries; flush wins over push
import fetch_pkg::*;

module fetch_fifo #(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         arst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t wdata,
    output fetch_entry_t rdata,
    output logic [AW:0]  count,
    output logic         full,
    output logic         empty
);
    fetch_entry_t mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;

    assign rdata = mem[rd_ptr];
    assign full  = count == (AW+1)'(DEPTH);
    assign empty = count == '0;

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(pop);
            count  <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC sequencing, imem reads and buffered valid/ready delivery
// FETCH_PERF_CNT_EN adds the perf_fetched / perf_flushes event counters
import fetch_pkg::*;

module instr_fetch_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  fetch_en,
    output logic                  imem_rd_en,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]           perf_fetched,
    output logic [31:0]           perf_flushes
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t          state;
    logic [ADDR_WIDTH-1:0] fetch_pc, resp_pc;
    logic                  pending, issue, push, pop, full, empty, unused_bits;
    logic [CW-1:0]         count;
    fetch_entry_t          wr_entry, head;

    // a pop in the same cycle earns no credit, so a push can never hit a full FIFO
    assign issue       = state == RUN && fetch_en && !redirect_valid && (count + CW'(pending)) < CW'(FIFO_DEPTH);
    assign push        = pending && !redirect_valid && !full;
    assign pop         = instr_valid && instr_ready;
    assign instr_valid = !empty;
    assign imem_rd_en  = issue;
    assign imem_addr   = fetch_pc;
    assign instr       = instr_valid ? head.instr : '0;
    assign instr_pc    = instr_valid ? head.pc : '0;
    assign wr_entry    = '{pc: resp_pc, instr: imem_rdata};
    assign unused_bits = ^redirect_pc[1:0];

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .arst_n(arst_n),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .wdata (wr_entry),
        .rdata (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            resp_pc  <= '0;
            pending  <= 1'b0;
        end else begin
            state    <= fetch_en ? RUN : IDLE;
            pending  <= issue;
            if (issue) resp_pc <= fetch_pc;
            fetch_pc <= redirect_valid ? {redirect_pc[ADDR_WIDTH-1:2], 2'b00} :
                        issue ? fetch_pc + ADDR_WIDTH'(INSTR_BYTES) : fetch_pc;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            perf_fetched <= '0;
            perf_flushes <= '0;
        end else begin
            perf_fetched <= perf_fetched + 32'(pop);
            perf_flushes <= perf_flushes + 32'(redirect_valid);
        end
    end
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: vector table plus PC/instr scoreboard for instr_fetch_unit
module tb_instr_fetch_unit;
    logic        clk = 1'b0;
    logic        arst_n, fetch_en, imem_rd_en, instr_valid, instr_ready, redirect_valid;
    logic [31:0] imem_addr, imem_rdata, instr, instr_pc, redirect_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_flushes;
`endif

    int          n_checks = 0;
    int          n_fail = 0;
    int          exp_fetched = 0;
    int          exp_flushes = 0;
    logic [31:0] exp_q [$];

    typedef struct {
        logic        fe;
        logic        rdy;
        logic        rd;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] pc;
    } vec_t;

    vec_t v [11];

    always #5 clk = ~clk;

    instr_fetch_unit #(.RESET_PC(32'h0)) dut (
        .clk           (clk),
        .arst_n        (arst_n),
        .fetch_en      (fetch_en),
        .imem_rd_en    (imem_rd_en),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched  (perf_fetched),
        .perf_flushes  (perf_flushes)
`endif
    );

    // 1-cycle-latency memory whose word encodes its own address
    always @(posedge clk) begin
        if (imem_rd_en) imem_rdata <= 32'h1000_0000 | imem_addr;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_from(input logic [31:0] pc);
        exp_q.delete();
        for (int i = 0; i < 64; i++) exp_q.push_back(pc + 32'(4 * i));
    endtask

    always @(negedge clk) begin
        logic [31:0] e;
        if (!arst_n) begin
            expect_from(32'h0);
            exp_fetched = 0;
            exp_flushes = 0;
        end else begin
            if (instr_valid && instr_ready) begin
                if (exp_q.size() == 0) check("sb_empty", 32'd0, 32'd1);
                else begin
                    e = exp_q.pop_front();
                    check("sb_pc", instr_pc, e);
                    check("sb_instr", instr, 32'h1000_0000 | e);
                end
                exp_fetched++;
            end
            if (redirect_valid) begin
                expect_from({redirect_pc[31:2], 2'b00});
                exp_flushes++;
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        arst_n = 1'b0;
        fetch_en = 1'b0;
        instr_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        #3;
        check("rst_rd_en", imem_rd_en, 1'b0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_valid", instr_valid, 1'b0);
        check("rst_instr", instr, 32'h0);
        check("rst_pc", instr_pc, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        arst_n = 1'b1;
    endtask

    task automatic wait_valid;
        int i;
        i = 0;
        @(negedge clk);
        while (!instr_valid && i < 20) begin
            @(negedge clk);
            i++;
        end
        check("wait_valid", instr_valid, 1'b1);
    endtask

    initial begin
        int reads;
        v[0]  = '{1, 1, 0, 32'h00, 0, 32'h0};
        v[1]  = '{1, 1, 1, 32'h00, 0, 32'h0};
        v[2]  = '{1, 1, 1, 32'h04, 0, 32'h0};
        v[3]  = '{1, 1, 1, 32'h08, 1, 32'h0};
        v[4]  = '{1, 1, 1, 32'h0C, 1, 32'h4};
        v[5]  = '{1, 0, 1, 32'h10, 1, 32'h8};
        v[6]  = '{0, 0, 0, 32'h14, 1, 32'h8};
        v[7]  = '{0, 1, 0, 32'h14, 1, 32'h8};
        v[8]  = '{0, 1, 0, 32'h14, 1, 32'hC};
        v[9]  = '{0, 1, 0, 32'h14, 1, 32'h10};
        v[10] = '{0, 1, 0, 32'h14, 0, 32'h0};
        arst_n = 1'b1;
        #1;
        do_reset;
        for (int i = 0; i < 11; i++) begin
            fetch_en = v[i].fe;
            instr_ready = v[i].rdy;
            @(negedge clk);
            check("vec_rd_en", imem_rd_en, v[i].rd);
            check("vec_addr", imem_addr, v[i].addr);
            check("vec_valid", instr_valid, v[i].vld);
            check("vec_pc", instr_pc, v[i].pc);
            step;
        end
        // backpressure: exactly FIFO_DEPTH reads then stall
        do_reset;
        fetch_en = 1'b1;
        reads = 0;
        repeat (12) begin
            @(negedge clk);
            if (imem_rd_en) reads++;
            step;
        end
        check("stall_reads", reads, 4);
        check("stall_rd_en", imem_rd_en, 1'b0);
        check("stall_valid", instr_valid, 1'b1);
        check("stall_pc", instr_pc, 32'h0);
        check("stall_instr", instr, 32'h1000_0000);
        instr_ready = 1'b1;
        reads = 0;
        repeat (8) begin
            @(negedge clk);
            if (imem_rd_en) reads++;
            step;
        end
        check("resume_reads", 32'(reads > 0), 32'd1);
        // redirect with 3 buffered entries and a read in flight
        do_reset;
        fetch_en = 1'b1;
        repeat (5) step;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0102;
        @(negedge clk);
        check("redir_pre_valid", instr_valid, 1'b1);
        check("redir_rd_en", imem_rd_en, 1'b0);
        step;
        redirect_valid = 1'b0;
        instr_ready = 1'b1;
        @(negedge clk);
        check("redir_n1_valid", instr_valid, 1'b0);
        check("redir_n1_rd_en", imem_rd_en, 1'b1);
        check("redir_n1_addr", imem_addr, 32'h100);
        step;
        @(negedge clk);
        check("redir_n2_valid", instr_valid, 1'b0);
        step;
        @(negedge clk);
        check("redir_n3_valid", instr_valid, 1'b1);
        check("redir_n3_pc", instr_pc, 32'h100);
        step;
        // back-to-back redirects
        repeat (4) step;
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        @(negedge clk);
        check("dbl_rd_en0", imem_rd_en, 1'b0);
        step;
        redirect_pc = 32'h80;
        @(negedge clk);
        check("dbl_rd_en1", imem_rd_en, 1'b0);
        step;
        redirect_valid = 1'b0;
        wait_valid;
        check("dbl_pc", instr_pc, 32'h80);
        step;
        // PC wrap
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step;
        redirect_valid = 1'b0;
        wait_valid;
        check("wrap_pc0", instr_pc, 32'hFFFF_FFFC);
        step;
        @(negedge clk);
        check("wrap_valid1", instr_valid, 1'b1);
        check("wrap_pc1", instr_pc, 32'h0);
        step;
        repeat (6) step;
        // asynchronous reset with two entries buffered
        instr_ready = 1'b0;
        step;
        check("mid_pre_valid", instr_valid, 1'b1);
        #2;
        arst_n = 1'b0;
        #1;
        check("mid_rd_en", imem_rd_en, 1'b0);
        check("mid_addr", imem_addr, 32'h0);
        check("mid_valid", instr_valid, 1'b0);
        check("mid_instr", instr, 32'h0);
        check("mid_pc", instr_pc, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        check("mid_perf_fetched", perf_fetched, 32'h0);
        check("mid_perf_flushes", perf_flushes, 32'h0);
`endif
        step;
        arst_n = 1'b1;
        instr_ready = 1'b1;
        wait_valid;
        check("post_rst_pc", instr_pc, 32'h0);
        step;
        repeat (6) step;
        redirect_valid = 1'b1;
        redirect_pc = 32'h200;
        step;
        redirect_valid = 1'b0;
        repeat (8) step;
        fetch_en = 1'b0;
        instr_ready = 1'b0;
        repeat (6) step;
`ifdef FETCH_PERF_CNT_EN
        check("perf_fetched", perf_fetched, 32'(exp_fetched));
        check("perf_flushes", perf_flushes, 32'(exp_flushes));
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
